program_loader: RTL and testbench

Boot-time writer for the instruction memory. Accepts a length-prefixed byte stream over a valid/ready handshake and packs it into 32-bit little-endian words. It issues one-cycle write strobes to the program RAM, which is based at byte address 0x40000 and indexed by word. The processor is held in reset through `CpuHold` until a complete image has landed.

---
 rtl/program_loader.sv | 165 ++++++++++++++++
 tb/tb_program_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: packs a length-prefixed byte stream into little-endian words for the program RAM.
// Optional trailing XOR checksum byte is enabled by defining LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int unsigned           MEMORY_DEPTH = 32,
    parameter int unsigned           DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = DATA_WIDTH'(32'h40000)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [7:0]            ByteData,
    input  logic                  ByteValid,
    output logic                  ByteReady,
    output logic                  WriteEnable,
    output logic [DATA_WIDTH-1:0] WriteAddress,
    output logic [DATA_WIDTH-1:0] WriteData,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error,
    output logic                  CpuHold
);

    localparam int unsigned LEN_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE,
        S_ERROR
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
    logic [1:0]       bcnt;
    logic [23:0]      wbuf;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       csum;
`endif

    logic             accept;
    logic [LEN_W-1:0] len_full;
    logic [LEN_W-1:0] idx_inc;

    assign accept   = ByteValid && ByteReady;
    assign len_full = {ByteData, len[7:0]};
    assign idx_inc  = LEN_W'(idx + LEN_W'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            len          <= '0;
            idx          <= '0;
            bcnt         <= '0;
            wbuf         <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
            ByteReady    <= 1'b0;
            WriteEnable  <= 1'b0;
            WriteAddress <= BASE_ADDRESS;
            WriteData    <= '0;
            Busy         <= 1'b0;
            Done         <= 1'b0;
            Error        <= 1'b0;
            CpuHold      <= 1'b1;
        end else begin
            WriteEnable <= 1'b0;
            case (state)
                // Start is honoured only while no load is in progress
                S_IDLE, S_DONE, S_ERROR: begin
                    if (Start) begin
                        state     <= S_LEN_LO;
                        idx       <= '0;
                        bcnt      <= '0;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= '0;
`endif
                        ByteReady <= 1'b1;
                        Busy      <= 1'b1;
                        Done      <= 1'b0;
                        Error     <= 1'b0;
                        CpuHold   <= 1'b1;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        len[7:0] <= ByteData;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len[15:8] <= ByteData;
                        if (len_full == '0) begin
                            state     <= S_DONE;
                            ByteReady <= 1'b0;
                            Busy      <= 1'b0;
                            Done      <= 1'b1;
                            CpuHold   <= 1'b0;
                        end else if (len_full > LEN_W'(MEMORY_DEPTH)) begin
                            state     <= S_ERROR;
                            ByteReady <= 1'b0;
                            Busy      <= 1'b0;
                            Error     <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                // Bytes shift in from the top so the 4th byte lands in bits [31:24]
                S_DATA: begin
                    if (accept) begin
                        bcnt <= 2'(bcnt + 2'd1);
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ ByteData;
`endif
                        if (bcnt == 2'd3) begin
                            WriteData    <= DATA_WIDTH'({ByteData, wbuf});
                            WriteAddress <= DATA_WIDTH'(BASE_ADDRESS + DATA_WIDTH'({idx, 2'b00}));
                            WriteEnable  <= 1'b1;
                            idx          <= idx_inc;
                            if (idx_inc == len) begin
`ifdef LOADER_CHECKSUM_EN
                                state <= S_CSUM;
`else
                                state     <= S_DONE;
                                ByteReady <= 1'b0;
                                Busy      <= 1'b0;
                                Done      <= 1'b1;
                                CpuHold   <= 1'b0;
`endif
                            end
                        end else begin
                            wbuf <= {ByteData, wbuf[23:8]};
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (accept) begin
                        ByteReady <= 1'b0;
                        Busy      <= 1'b0;
                        if (ByteData == csum) begin
                            state   <= S_DONE;
                            Done    <= 1'b1;
                            CpuHold <= 1'b0;
                        end else begin
                            state <= S_ERROR;
                            Error <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Scoreboarded random test for program_loader; expected writes come from a per-image word model.
`timescale 1ns/1ps
module tb_program_loader;

    localparam logic [31:0] BASE = 32'h40000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [7:0]  ByteData = '0;
    logic        ByteValid = 1'b0;
    logic        ByteReady;
    logic        WriteEnable;
    logic [31:0] WriteAddress;
    logic [31:0] WriteData;
    logic        Busy, Done, Error, CpuHold;

    program_loader dut (
        .clk(clk), .reset(reset), .Start(Start),
        .ByteData(ByteData), .ByteValid(ByteValid), .ByteReady(ByteReady),
        .WriteEnable(WriteEnable), .WriteAddress(WriteAddress), .WriteData(WriteData),
        .Busy(Busy), .Done(Done), .Error(Error), .CpuHold(CpuHold)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] expq[$];
    logic [31:0] img[64];
    logic [63:0] mon_e;
    int          maxgap = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected word
    always @(negedge clk) begin
        if (WriteEnable === 1'b1) begin
            if (expq.size() == 0) begin
                chk("unexpected_write", {WriteAddress, WriteData}, 64'h0);
            end else begin
                mon_e = expq.pop_front();
                chk("write_addr_data", {WriteAddress, WriteData}, mon_e);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int gap;
        int tries;
        gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
        for (int g = 0; g < gap; g++) begin
            ByteValid = 1'b0;
            Start = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        Start = 1'b0;
        ByteData = b;
        ByteValid = 1'b1;
        tries = 0;
        while (ByteReady !== 1'b1 && tries < 20) begin
            @(negedge clk);
            tries++;
        end
        if (ByteReady !== 1'b1) chk("byte_ready_timeout", {63'h0, ByteReady}, 64'h1);
        @(negedge clk);
        ByteValid = 1'b0;
    endtask

    task automatic start_pulse();
        Start = 1'b1;
        @(negedge clk);
        Start = 1'b0;
        chk("busy_ready_after_start", {62'h0, Busy, ByteReady}, 64'h3);
    endtask

    task automatic check_reset_vals(input string nm);
        chk(nm, {ByteReady, WriteEnable, Busy, Done, Error, CpuHold, WriteAddress, WriteData[25:0]},
            {6'b000001, BASE, 26'h0});
        chk("reset_wdata_hi", {58'h0, WriteData[31:26]}, 64'h0);
    endtask

    // Reference: words of img[0..n-1] land at BASE+4i; outcome from length and checksum rules
    task automatic do_load(input int n, input bit bad_csum);
        logic [7:0] x;
        bit exp_done;
        bit exp_err;
        x = 8'h00;
        start_pulse();
        send_byte(n[7:0]);
        send_byte(n[15:8]);
        if (n == 0) begin
            exp_done = 1'b1; exp_err = 1'b0;
        end else if (n > 32) begin
            exp_done = 1'b0; exp_err = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                expq.push_back({BASE + 32'(4 * i), img[i]});
                for (int k = 0; k < 4; k++) begin
                    x = x ^ img[i][8*k +: 8];
                    send_byte(img[i][8*k +: 8]);
                end
            end
`ifdef LOADER_CHECKSUM_EN
            send_byte(bad_csum ? (x ^ 8'h07) : x);
            exp_done = !bad_csum;
            exp_err  = bad_csum;
`else
            exp_done = 1'b1;
            exp_err  = 1'b0;
`endif
        end
        chk("end_flags_done_err_hold_busy_ready", {59'h0, Done, Error, CpuHold, Busy, ByteReady},
            {59'h0, exp_done, exp_err, !exp_done, 1'b0, 1'b0});
        @(negedge clk);
        @(negedge clk);
        chk("pending_writes_after_load", 64'(expq.size()), 64'h0);
        expq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #23;
        check_reset_vals("reset_values");
        reset = 1'b1;
        @(negedge clk);

        // Directed image from the bring-up example, good then bad checksum
        img[0] = 32'h20080013;
        img[1] = 32'h10000008;
        do_load(2, 1'b0);
        do_load(2, 1'b1);
        do_load(33, 1'b0);
        do_load(300, 1'b0);
        do_load(0, 1'b0);

        // Three words with random valid gaps and stray Start pulses
        maxgap = 3;
        for (int i = 0; i < 3; i++) img[i] = $urandom;
        do_load(3, 1'b0);
        maxgap = 0;

        // Reset after six data bytes: only word 0 was written
        for (int i = 0; i < 4; i++) img[i] = $urandom;
        start_pulse();
        send_byte(8'd4);
        send_byte(8'd0);
        expq.push_back({BASE, img[0]});
        for (int k = 0; k < 4; k++) send_byte(img[0][8*k +: 8]);
        for (int k = 0; k < 2; k++) send_byte(img[1][8*k +: 8]);
        #2 reset = 1'b0;
        #1 check_reset_vals("reset_mid_load");
        chk("pending_before_reset", 64'(expq.size()), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        maxgap = 2;
        do_load(4, 1'b0);

        // Random images including full depth
        for (int t = 0; t < 8; t++) begin
            int n;
            n = (t == 0) ? 32 : int'($urandom_range(32, 1));
            for (int i = 0; i < n; i++) img[i] = $urandom;
            maxgap = int'($urandom_range(2, 0));
            do_load(n, (t % 3) == 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
